vga_console_writer: RTL and testbench
=====================================

VGA_CONSOLE_WRITER -- requirements
Module: vga_console_writer

Interface
REQ-001 SHALL have parameter TEXT_COLUMNS, default 10: characters per text line.
REQ-002 SHALL have parameter TEXT_ROWS, default 5: text lines per frame.
REQ-003 SHALL have parameter CLEAR_CHAR, default 8'h20: code written into cleared cells.
REQ-004 SHALL define derived widths: AW = $clog2(TEXT_COLUMNS*TEXT_ROWS), CW = $clog2(TEXT_COLUMNS), RW = $clog2(TEXT_ROWS).
REQ-005 SHALL have port pixel_clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port in_data, input, 8: host character byte.
REQ-008 SHALL have port in_valid, input, 1: in_data valid.
REQ-009 SHALL have port in_ready, output, 1: block accepts a byte this cycle.
REQ-010 SHALL have port ram_wr_en, output, 1: character RAM write strobe.
REQ-011 SHALL have port ram_wr_addr, output, AW: write address, row-major, no inter-line padding.
REQ-012 SHALL have port ram_wr_data, output, 8: write data.
REQ-013 SHALL have ports cursor_row (RW), cursor_column (CW), cursor_address (AW), all outputs: cursor position, cursor_address = cursor_row*TEXT_COLUMNS + cursor_column.
REQ-014 SHALL have port busy, output, 1: clear sequence in progress.

Function
REQ-015 SHALL implement a two-state FSM: CLEAR and READY.
REQ-016 in_ready SHALL equal (state == READY); busy SHALL equal (state == CLEAR); a byte is accepted iff in_valid && in_ready on a rising edge.
REQ-017 All RAM and cursor outputs SHALL be registered; a write caused by an accepted byte SHALL appear on ram_wr_* the cycle after acceptance, coincident with the updated cursor.
REQ-018 ram_wr_en SHALL be 1 for exactly one cycle per write and 0 in READY cycles following no write-producing acceptance.
REQ-019 Printable byte (any value except 8'h08, 8'h0A, 8'h0C, 8'h0D) SHALL write in_data at cursor_address, then advance the cursor one column.
REQ-020 Column advance at cursor_column == TEXT_COLUMNS-1 SHALL set column 0 and advance row; row advance at TEXT_ROWS-1 SHALL wrap to row 0 (no scrolling); cursor_address wraps from N-1 to 0, N = TEXT_COLUMNS*TEXT_ROWS.
REQ-021 8'h0D (CR) SHALL set cursor_column to 0, keep row, produce no write.
REQ-022 8'h0A (LF) SHALL set cursor_column to 0 and advance row with wrap per REQ-020, produce no write.
REQ-023 8'h08 (BS) with cursor_column > 0 SHALL decrement column and write CLEAR_CHAR at the new cursor_address; with cursor_column == 0 SHALL produce no write and no cursor change.
REQ-024 8'h0C (FF) SHALL enter CLEAR and set cursor to row 0, column 0, without writing on the acceptance cycle.
REQ-025 In CLEAR, each cycle SHALL write CLEAR_CHAR to addresses 0, 1, ..., N-1 in order, one per cycle, using an AW-bit counter starting at 0.
REQ-026 On the edge that presents address N-1, state SHALL become READY; in_ready rises in that same cycle; a clear is exactly N write cycles.
REQ-027 in_data and in_valid SHALL be ignored while in CLEAR; no byte is lost since in_ready is 0.
REQ-028 cursor_address SHALL be maintained incrementally (no multiplier); backspace decrements it by 1, CR subtracts cursor_column, LF sets it to the start of the next row.

Reset
REQ-029 On reset_n low, asynchronously: state = CLEAR, clear counter = 0, ram_wr_en = 0, ram_wr_addr = 0, ram_wr_data = 0, cursor_row/column/address = 0; hence in_ready = 0, busy = 1.
REQ-030 After reset release, the block SHALL perform a full clear (REQ-025) before accepting any byte.
REQ-031 Reset asserted mid-clear or mid-write SHALL abort immediately and restart the clear from address 0 after release.

Verification (TEXT_COLUMNS=10, TEXT_ROWS=5, CLEAR_CHAR=8'h20)
REQ-032 Release reset -> 50 consecutive writes of 8'h20 to addresses 0..49, then in_ready=1, busy=0, cursor 0.
REQ-033 Send "A","B" back-to-back -> writes (0,8'h41),(1,8'h42) one cycle after each acceptance; cursor_address=2, column 2.
REQ-034 Send 12 printable bytes from cursor 0, then 8'h0D, then 8'h0A -> last write at address 11; after CR cursor=(row1,col0,addr10); after LF cursor=(row2,col0,addr20); no writes for CR/LF.
REQ-035 Cursor at address 49, send "Z" -> write (49,8'h5A), cursor wraps to (0,0,0); then 8'h08 at column 0 -> no write, cursor unchanged.
REQ-036 At cursor (row3,col4), send 8'h08 -> write (33,8'h20), cursor (3,3,33); then 8'h0C with in_valid held -> in_ready low for 50 cycles, addresses 0..49 cleared, cursor 0, next byte accepted only after.
REQ-037 Assert reset_n low during clear at address 20 -> all outputs at reset values immediately; after release clear restarts at address 0.

Source files
------------

// File: rtl/vga_console_writer_if.sv
// Host byte stream and character-RAM write port of the console writer.
// The master side is the host/RAM, the slave side is the writer itself.
interface vga_console_writer_if #(
  parameter int TEXT_COLUMNS = 10,
  parameter int TEXT_ROWS    = 5
);
  localparam int AW = $clog2(TEXT_COLUMNS * TEXT_ROWS);

  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [7:0]    ram_wr_data;

  modport master (
    output in_data, in_valid,
    input  in_ready, ram_wr_en, ram_wr_addr, ram_wr_data
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, ram_wr_en, ram_wr_addr, ram_wr_data
  );
endinterface

// File: rtl/vga_console_writer.sv
// Text console writer: turns a host byte stream into character-RAM writes,
// tracking a wrapping cursor and clearing the whole screen on reset or form feed.
module vga_console_writer #(
  parameter int          TEXT_COLUMNS = 10,
  parameter int          TEXT_ROWS    = 5,
  parameter logic [7:0]  CLEAR_CHAR   = 8'h20,
  localparam int         AW = $clog2(TEXT_COLUMNS * TEXT_ROWS),
  localparam int         CW = $clog2(TEXT_COLUMNS),
  localparam int         RW = $clog2(TEXT_ROWS)
) (
  input  logic                 pixel_clk,
  input  logic                 reset_n,
  vga_console_writer_if.slave  bus,
  output logic [RW-1:0]        cursor_row,
  output logic [CW-1:0]        cursor_column,
  output logic [AW-1:0]        cursor_address,
  output logic                 busy
);

  localparam logic [7:0]    CHAR_BS   = 8'h08;
  localparam logic [7:0]    CHAR_LF   = 8'h0A;
  localparam logic [7:0]    CHAR_FF   = 8'h0C;
  localparam logic [7:0]    CHAR_CR   = 8'h0D;
  localparam logic [AW-1:0] ADDR_LAST = AW'(TEXT_COLUMNS * TEXT_ROWS - 1);
  localparam logic [AW-1:0] COLS_AW   = AW'(TEXT_COLUMNS);
  localparam logic [CW-1:0] COL_LAST  = CW'(TEXT_COLUMNS - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(TEXT_ROWS - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] clear_cnt_q, clear_cnt_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          accept;
  logic [RW-1:0] next_row;

  assign accept   = bus.in_valid && (state_q == READY);
  assign next_row = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) state_q <= CLEAR;
    else          state_q <= state_d;
  end

  // Clearing ends on the same edge that presents the last address.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (clear_cnt_q == ADDR_LAST) state_d = READY;
      READY:   if (accept && bus.in_data == CHAR_FF) state_d = CLEAR;
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    bus.in_ready = (state_q == READY);
    busy         = (state_q == CLEAR);
    clear_cnt_d  = clear_cnt_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    row_d        = row_q;
    col_d        = col_q;
    addr_d       = addr_q;
    if (state_q == CLEAR) begin
      wr_en_d     = 1'b1;
      wr_addr_d   = clear_cnt_q;
      wr_data_d   = CLEAR_CHAR;
      clear_cnt_d = (clear_cnt_q == ADDR_LAST) ? '0 : clear_cnt_q + 1'b1;
    end else if (accept) begin
      // The linear address is kept incrementally alongside row/column.
      case (bus.in_data)
        CHAR_CR: begin
          col_d  = '0;
          addr_d = addr_q - AW'(col_q);
        end
        CHAR_LF: begin
          col_d  = '0;
          row_d  = next_row;
          addr_d = (row_q == ROW_LAST) ? '0 : addr_q - AW'(col_q) + COLS_AW;
        end
        CHAR_BS: begin
          if (col_q != '0) begin
            col_d     = col_q - 1'b1;
            addr_d    = addr_q - 1'b1;
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q - 1'b1;
            wr_data_d = CLEAR_CHAR;
          end
        end
        CHAR_FF: begin
          row_d       = '0;
          col_d       = '0;
          addr_d      = '0;
          clear_cnt_d = '0;
        end
        default: begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = bus.in_data;
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = next_row;
          end else begin
            col_d = col_q + 1'b1;
          end
          addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      clear_cnt_q <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      row_q       <= '0;
      col_q       <= '0;
      addr_q      <= '0;
    end else begin
      clear_cnt_q <= clear_cnt_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      row_q       <= row_d;
      col_q       <= col_d;
      addr_q      <= addr_d;
    end
  end

  assign bus.ram_wr_en   = wr_en_q;
  assign bus.ram_wr_addr = wr_addr_q;
  assign bus.ram_wr_data = wr_data_q;
  assign cursor_row      = row_q;
  assign cursor_column   = col_q;
  assign cursor_address  = addr_q;

endmodule

// File: tb/tb_vga_console_writer.sv
// Directed bench for vga_console_writer: a reference cursor model pushes expected
// RAM writes into a scoreboard that is drained on every falling clock edge.
module tb_vga_console_writer;

  localparam int         C   = 10;
  localparam int         R   = 5;
  localparam int         N   = C * R;
  localparam logic [7:0] CLR = 8'h20;

  logic       pixel_clk;
  logic       reset_n;
  logic [2:0] cursor_row;
  logic [3:0] cursor_column;
  logic [5:0] cursor_address;
  logic       busy;

  vga_console_writer_if #(.TEXT_COLUMNS(C), .TEXT_ROWS(R)) bus();

  vga_console_writer #(
    .TEXT_COLUMNS(C),
    .TEXT_ROWS(R),
    .CLEAR_CHAR(CLR)
  ) dut (
    .pixel_clk(pixel_clk),
    .reset_n(reset_n),
    .bus(bus),
    .cursor_row(cursor_row),
    .cursor_column(cursor_column),
    .cursor_address(cursor_address),
    .busy(busy)
  );

  int          n_asserts = 0;
  int          n_fail    = 0;
  logic [13:0] sb[$];
  int          mrow;
  int          mcol;

  initial begin
    pixel_clk = 1'b0;
    forever #5 pixel_clk = ~pixel_clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Scoreboard sample on the falling edge, then advance to just after the rising edge.
  task automatic cycle();
    logic [13:0] e;
    @(negedge pixel_clk);
    if (bus.ram_wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_write", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("wr_addr", 32'(bus.ram_wr_addr), 32'(e[13:8]));
        checkOutput("wr_data", 32'(bus.ram_wr_data), 32'(e[7:0]));
      end
    end
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic pushWrite(input int addr, input logic [7:0] data);
    sb.push_back({6'(addr), data});
  endtask

  task automatic pushClear();
    for (int i = 0; i < N; i++) pushWrite(i, CLR);
  endtask

  task automatic checkCursor();
    checkOutput("cursor_row", 32'(cursor_row), mrow);
    checkOutput("cursor_column", 32'(cursor_column), mcol);
    checkOutput("cursor_address", 32'(cursor_address), mrow * C + mcol);
  endtask

  task automatic checkResetState();
    checkOutput("rst_wr_en", 32'(bus.ram_wr_en), 0);
    checkOutput("rst_wr_addr", 32'(bus.ram_wr_addr), 0);
    checkOutput("rst_wr_data", 32'(bus.ram_wr_data), 0);
    checkOutput("rst_row", 32'(cursor_row), 0);
    checkOutput("rst_column", 32'(cursor_column), 0);
    checkOutput("rst_address", 32'(cursor_address), 0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 0);
    checkOutput("rst_busy", 32'(busy), 1);
  endtask

  task automatic waitReady(input int expected_cycles);
    int c = 0;
    while (bus.in_ready !== 1'b1 && c < 200) begin
      cycle();
      c++;
    end
    checkOutput("clear_cycles", c, expected_cycles);
    checkOutput("ready_at_last_addr", 32'(bus.ram_wr_addr), N - 1);
    checkOutput("busy_after_clear", 32'(busy), 0);
  endtask

  task automatic checkDrained();
    cycle();
    cycle();
    checkOutput("sb_drained", sb.size(), 0);
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    int w = 0;
    bit exp_wr = 1'b0;
    while (bus.in_ready !== 1'b1 && w < 200) begin
      cycle();
      w++;
    end
    if (w == 200) checkOutput("ready_timeout", 32'd0, 32'd1);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    cycle();
    bus.in_valid = 1'b0;
    case (b)
      8'h0D: mcol = 0;
      8'h0A: begin mcol = 0; mrow = (mrow + 1) % R; end
      8'h08: if (mcol > 0) begin mcol--; pushWrite(mrow * C + mcol, CLR); exp_wr = 1'b1; end
      8'h0C: begin mrow = 0; mcol = 0; pushClear(); end
      default: begin
        pushWrite(mrow * C + mcol, b);
        exp_wr = 1'b1;
        mcol++;
        if (mcol == C) begin mcol = 0; mrow = (mrow + 1) % R; end
      end
    endcase
    checkOutput("wr_en_after_accept", 32'(bus.ram_wr_en), 32'(exp_wr));
    checkOutput("in_ready_after_accept", 32'(bus.in_ready), 32'(b != 8'h0C));
    checkCursor();
  endtask

  initial begin
    int c;
    reset_n      = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    mrow         = 0;
    mcol         = 0;
    #2 reset_n = 1'b0;
    #1 checkResetState();
    cycle();
    cycle();
    checkResetState();

    $display("[TB] power-up clear");
    reset_n = 1'b1;
    pushClear();
    waitReady(N);
    checkCursor();
    checkDrained();

    $display("[TB] back-to-back A B");
    applyStimulus(8'h41);
    applyStimulus(8'h42);
    checkOutput("ab_address", 32'(cursor_address), 2);
    checkOutput("ab_column", 32'(cursor_column), 2);
    checkDrained();

    $display("[TB] 12 printables then CR LF");
    applyStimulus(8'h0C);
    waitReady(N);
    checkDrained();
    for (int i = 0; i < 12; i++) applyStimulus(8'h61 + 8'(i));
    checkOutput("last_write_addr", 32'(bus.ram_wr_addr), 11);
    applyStimulus(8'h0D);
    checkOutput("cr_row", 32'(cursor_row), 1);
    checkOutput("cr_address", 32'(cursor_address), 10);
    applyStimulus(8'h0A);
    checkOutput("lf_row", 32'(cursor_row), 2);
    checkOutput("lf_column", 32'(cursor_column), 0);
    checkOutput("lf_address", 32'(cursor_address), 20);
    checkDrained();

    $display("[TB] backspace mid-line");
    for (int i = 0; i < 14; i++) applyStimulus(8'h30 + 8'(i));
    checkOutput("pre_bs_address", 32'(cursor_address), 34);
    applyStimulus(8'h08);
    checkOutput("bs_wr_addr", 32'(bus.ram_wr_addr), 33);
    checkOutput("bs_wr_data", 32'(bus.ram_wr_data), 32'h20);
    checkOutput("bs_row", 32'(cursor_row), 3);
    checkOutput("bs_column", 32'(cursor_column), 3);
    checkOutput("bs_address", 32'(cursor_address), 33);
    checkDrained();

    $display("[TB] form feed with in_valid held");
    bus.in_data  = 8'h0C;
    bus.in_valid = 1'b1;
    cycle();
    mrow = 0;
    mcol = 0;
    pushClear();
    bus.in_data = 8'h51;
    checkOutput("ff_no_write", 32'(bus.ram_wr_en), 0);
    checkOutput("ff_busy", 32'(busy), 1);
    checkCursor();
    waitReady(N);
    pushWrite(0, 8'h51);
    mcol = 1;
    cycle();
    bus.in_valid = 1'b0;
    checkOutput("held_byte_write", 32'(bus.ram_wr_en), 1);
    checkCursor();
    checkDrained();

    $display("[TB] wrap at last cell");
    for (int i = 0; i < 48; i++) applyStimulus(8'h41 + 8'(i % 26));
    checkOutput("pre_wrap_address", 32'(cursor_address), 49);
    applyStimulus(8'h5A);
    checkOutput("wrap_wr_addr", 32'(bus.ram_wr_addr), 49);
    checkOutput("wrap_wr_data", 32'(bus.ram_wr_data), 32'h5A);
    checkOutput("wrap_address", 32'(cursor_address), 0);
    applyStimulus(8'h08);
    checkOutput("bs_col0_address", 32'(cursor_address), 0);
    checkDrained();

    $display("[TB] reset during clear");
    applyStimulus(8'h0C);
    c = 0;
    while (!(bus.ram_wr_en === 1'b1 && bus.ram_wr_addr === 6'd20) && c < 100) begin
      cycle();
      c++;
    end
    checkOutput("reached_addr20", 32'(c < 100), 1);
    reset_n = 1'b0;
    #1 checkResetState();
    sb.delete();
    mrow = 0;
    mcol = 0;
    cycle();
    cycle();
    checkResetState();
    reset_n = 1'b1;
    pushClear();
    waitReady(N);
    checkCursor();
    checkDrained();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
